// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//   This block holds the architectural program counter. It fetches the
//   instruction at that PC over a request/grant/response handshake and holds
//   the instruction for execution. On commit it loads the next PC. It also
//   detects the self-loop halt and counts retired instructions.
//
// Build option:
//   PC_ALIGN_CHECK_EN
//     Defined:   a commit to a target that is not word aligned halts the core
//                with the sticky `misaligned` flag set. The PC and the retire
//                count stay unchanged.
//     Undefined: the target's low two bits are dropped, and `misaligned` is
//                tied to 0.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   next_pc, commit  next PC from downstream; advance when commit is high in EXEC
//   pc               current architectural PC
//   imem_req/addr    fetch request and address (address always equals pc)
//   imem_gnt         memory accepted the request
//   imem_rvalid/rdata  fetch response
//   inst, inst_valid latched instruction and its valid flag (valid in EXEC)
//   halted           sticky halt indicator
//   misaligned       sticky misaligned-target indicator
//   retire_cnt       committed-instruction count (wraps at 2^32)
// -----------------------------------------------------------------------------
module pc_fetch #(
    parameter logic [31:0] RESET_PC          = 32'h0000_0000,
    parameter bit          HALT_ON_SELF_LOOP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    input  logic        commit,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] cnt_q, cnt_d;
    logic        self_loop;

    // Self-loop compares the raw target with the current PC.
    assign self_loop = HALT_ON_SELF_LOOP && (next_pc == pc_q);

`ifdef PC_ALIGN_CHECK_EN
    logic mis_q, mis_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            cnt_q   <= 32'h0;
`ifdef PC_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
`ifdef PC_ALIGN_CHECK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            // A response seen in REQ is ignored. Only the grant moves us on.
            S_REQ: begin
                if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (commit) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        cnt_d   = cnt_q + 32'd1;
                        state_d = self_loop ? S_HALT : S_REQ;
                    end
`else
                    pc_d    = {next_pc[31:2], 2'b00};
                    cnt_d   = cnt_q + 32'd1;
                    state_d = self_loop ? S_HALT : S_REQ;
`endif
                end
            end
            S_HALT: begin
                // Exit only through reset.
            end
            default: state_d = S_REQ;
        endcase
    end

    // Reset parks the FSM in REQ. Gating with rst_n keeps the request low
    // while reset is held, so it rises right after release.
    assign imem_req   = (state_q == S_REQ) && rst_n;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_valid = (state_q == S_EXEC);
    assign halted     = (state_q == S_HALT);
    assign retire_cnt = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misaligned = mis_q;
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        commit;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        halted;
    logic        misaligned;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: what the architecture should show.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(32'h0), .HALT_ON_SELF_LOOP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .commit(commit), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst(inst),
        .inst_valid(inst_valid), .halted(halted), .misaligned(misaligned),
        .retire_cnt(retire_cnt)
    );

    // Advance one clock. Both driving and sampling happen 1 time unit after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; commit = 1'b0; next_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        m_pc = 32'h0; m_cnt = 32'h0;
    endtask

    // Single-cycle fetch: grant now, then data on the next cycle.
    task automatic do_fetch(input logic [31:0] data);
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = data; tick(); imem_rvalid = 1'b0;
    endtask

    task automatic do_commit(input logic [31:0] npc);
        commit = 1'b1; next_pc = npc; tick(); commit = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; commit = 1'b0; next_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        tick();
        n_checks++;
        if ({pc, inst, inst_valid, imem_req, halted, misaligned, retire_cnt} !== {32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0})
            $display("FAIL reset_values pc=%h inst=%h iv=%b req=%b halt=%b mis=%b cnt=%0d", pc, inst, inst_valid, imem_req, halted, misaligned, retire_cnt);
        else n_pass++;
        rst_n = 1'b1; #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL reset_release_req req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_basic_seq();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc)
                $display("FAIL seq_addr_%0d req=%b addr=%h expected 1/%h", k, imem_req, imem_addr, m_pc);
            else n_pass++;
            do_fetch(32'h1000 + k);
            n_checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h1000 + k)
                $display("FAIL seq_inst_%0d iv=%b inst=%h expected 1/%h", k, inst_valid, inst, 32'h1000 + k);
            else n_pass++;
            do_commit(m_pc + 32'd4);
            m_pc += 32'd4; m_cnt++;
        end
        n_checks++;
        if (retire_cnt !== 32'd3 || imem_addr !== 32'hC || imem_req !== 1'b1)
            $display("FAIL seq_retire cnt=%0d addr=%h req=%b expected 3/0000000c/1", retire_cnt, imem_addr, imem_req);
        else n_pass++;
    endtask

    task automatic test_gnt_stall();
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0)
                $display("FAIL stall_cycle_%0d req=%b addr=%h iv=%b expected 1/0/0", c, imem_req, imem_addr, inst_valid);
            else n_pass++;
            if (c < 4) tick();
        end
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0)
                $display("FAIL stall_wait_%0d req=%b iv=%b expected 0/0", c, imem_req, inst_valid);
            else n_pass++;
            tick();
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b1 || inst !== 32'hDEAD_BEEF)
            $display("FAIL stall_inst iv=%b inst=%h expected 1/deadbeef", inst_valid, inst);
        else n_pass++;
    endtask

    task automatic test_commit_outside_exec();
        apply_reset();
        commit = 1'b1; next_pc = 32'h100;
        tick();
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        tick();
        commit = 1'b0;
        n_checks++;
        if (pc !== 32'h0 || retire_cnt !== 32'h0 || inst_valid !== 1'b0)
            $display("FAIL commit_outside pc=%h cnt=%0d iv=%b expected 0/0/0", pc, retire_cnt, inst_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        do_fetch(32'h11); do_commit(32'h4);
        do_fetch(32'h22); do_commit(32'h8);
        imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
        n_checks++;
        if (pc !== 32'h8 || imem_req !== 1'b0 || retire_cnt !== 32'd2)
            $display("FAIL midwait_setup pc=%h req=%b cnt=%0d expected 8/0/2", pc, imem_req, retire_cnt);
        else n_pass++;
        #2 rst_n = 1'b0; #1;
        n_checks++;
        if (pc !== 32'h0 || inst_valid !== 1'b0 || retire_cnt !== 32'h0 || inst !== 32'h0)
            $display("FAIL midwait_reset pc=%h iv=%b cnt=%0d inst=%h expected 0/0/0/0", pc, inst_valid, retire_cnt, inst);
        else n_pass++;
        tick();
        rst_n = 1'b1; #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL midwait_refetch req=%b addr=%h expected 1/0", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] npc, data;
        int stall, lat, dly;
        apply_reset();
        for (int it = 0; it < 40; it++) begin
            stall = $urandom_range(0, 3);
            for (int c = 0; c < stall; c++) begin
                // A stray response during REQ must be ignored.
                imem_rvalid = ($urandom_range(0, 1) == 1); imem_rdata = $urandom;
                tick();
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== m_pc || inst_valid !== 1'b0)
                    $display("FAIL rand_req it=%0d req=%b addr=%h iv=%b expected 1/%h/0", it, imem_req, imem_addr, inst_valid, m_pc);
                else n_pass++;
            end
            imem_rvalid = 1'b0;
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc)
                $display("FAIL rand_grant it=%0d req=%b addr=%h expected 1/%h", it, imem_req, imem_addr, m_pc);
            else n_pass++;
            imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
            lat = $urandom_range(0, 3);
            for (int c = 0; c < lat; c++) begin
                commit = ($urandom_range(0, 1) == 1); next_pc = $urandom;
                tick();
            end
            commit = 1'b0;
            data = $urandom;
            imem_rvalid = 1'b1; imem_rdata = data; tick(); imem_rvalid = 1'b0;
            n_checks++;
            if (pc !== m_pc || retire_cnt !== m_cnt || imem_req !== 1'b0)
                $display("FAIL rand_wait it=%0d pc=%h cnt=%0d req=%b expected %h/%0d/0", it, pc, retire_cnt, imem_req, m_pc, m_cnt);
            else n_pass++;
            dly = $urandom_range(0, 2);
            for (int c = 0; c <= dly; c++) begin
                n_checks++;
                if (inst_valid !== 1'b1 || inst !== data)
                    $display("FAIL rand_exec it=%0d iv=%b inst=%h expected 1/%h", it, inst_valid, inst, data);
                else n_pass++;
                if (c < dly) begin
                    imem_rdata = $urandom;
                    tick();
                end
            end
            npc = $urandom;
`ifdef PC_ALIGN_CHECK_EN
            npc = npc & 32'hFFFF_FFFC;
`endif
            if (npc == m_pc) npc = npc ^ 32'h10;
            do_commit(npc);
            m_pc  = npc & 32'hFFFF_FFFC;
            m_cnt = m_cnt + 32'd1;
            n_checks++;
            if (pc !== m_pc || retire_cnt !== m_cnt || inst_valid !== 1'b0 || halted !== 1'b0)
                $display("FAIL rand_commit it=%0d pc=%h cnt=%0d iv=%b halt=%b expected %h/%0d/0/0", it, pc, retire_cnt, inst_valid, halted, m_pc, m_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_misaligned();
        apply_reset();
        do_fetch(32'h55);
        do_commit(32'h6);
`ifdef PC_ALIGN_CHECK_EN
        n_checks++;
        if (misaligned !== 1'b1 || halted !== 1'b1 || pc !== 32'h0 || retire_cnt !== 32'h0 || imem_req !== 1'b0)
            $display("FAIL misalign_halt mis=%b halt=%b pc=%h cnt=%0d req=%b expected 1/1/0/0/0", misaligned, halted, pc, retire_cnt, imem_req);
        else n_pass++;
`else
        n_checks++;
        if (misaligned !== 1'b0 || halted !== 1'b0 || pc !== 32'h4 || retire_cnt !== 32'd1 || imem_req !== 1'b1 || imem_addr !== 32'h4)
            $display("FAIL misalign_mask mis=%b halt=%b pc=%h cnt=%0d req=%b addr=%h expected 0/0/4/1/1/4", misaligned, halted, pc, retire_cnt, imem_req, imem_addr);
        else n_pass++;
`endif
    endtask

    task automatic test_halt();
        apply_reset();
        do_fetch(32'h77); do_commit(32'h30);
        do_fetch(32'h88); do_commit(32'h30);
        n_checks++;
        if (halted !== 1'b1 || pc !== 32'h30 || retire_cnt !== 32'd2 || inst_valid !== 1'b0)
            $display("FAIL halt_entry halt=%b pc=%h cnt=%0d iv=%b expected 1/30/2/0", halted, pc, retire_cnt, inst_valid);
        else n_pass++;
        for (int c = 0; c < 20; c++) begin
            commit = ($urandom_range(0, 1) == 1); next_pc = $urandom;
            imem_gnt = ($urandom_range(0, 1) == 1); imem_rvalid = ($urandom_range(0, 1) == 1);
            tick();
            n_checks++;
            if (imem_req !== 1'b0 || halted !== 1'b1 || retire_cnt !== 32'd2 || pc !== 32'h30 || inst_valid !== 1'b0)
                $display("FAIL halt_hold_%0d req=%b halt=%b cnt=%0d pc=%h iv=%b expected 0/1/2/30/0", c, imem_req, halted, retire_cnt, pc, inst_valid);
            else n_pass++;
        end
        commit = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_seq();
        test_gnt_stall();
        test_commit_outside_exec();
        test_reset_mid_wait();
        test_random();
        test_misaligned();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
